// File: rtl/misc_seq_ctrl.sv
// misc_seq_ctrl: job sequencer in front of the Misc unit (clear, stream with auto-indices, sort drain, done)
// Ports: clk/rst (sync, active-high); cmd_* job command handshake (len, asce, idx_base, fun_id);
// abort cancels an active job; in_* sample stream; misc_* registered drive of the Misc unit;
// busy/done/aborted job status. Optional MISC_SEQ_CTRL_PERF_EN adds perf_stall/perf_jobs counters.
module misc_seq_ctrl #(
    parameter int WIDTH    = 32,
    parameter int LEN_W    = 16,
    parameter int SORT_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_asce,
    input  logic [WIDTH-1:0] cmd_idx_base,
    input  logic [2:0]       cmd_fun_id,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] misc_in,
    output logic [WIDTH-1:0] misc_index,
    output logic [2:0]       misc_fun_id,
    output logic             misc_asce,
    output logic             misc_is_start,
    output logic             misc_clear_reg,
    output logic             busy,
    output logic             done,
    output logic             aborted
`ifdef MISC_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_stall,
    output logic [31:0]      perf_jobs
`endif
);
    localparam int WW = $clog2(SORT_LAT + 1);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, FIN} state_t;
    state_t state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [WIDTH-1:0] base_q, base_d, misc_in_q, misc_in_d, misc_index_q, misc_index_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [2:0]       misc_fun_id_q, misc_fun_id_d;
    logic             misc_asce_q, misc_asce_d, misc_is_start_q, misc_is_start_d;
    logic             misc_clear_reg_q, misc_clear_reg_d, done_q, done_d, aborted_q, aborted_d;
    logic             acc, hs, take_abort;
    assign cmd_ready  = state_q == IDLE;
    assign in_ready   = state_q == STREAM;
    assign busy       = state_q != IDLE;
    assign acc        = cmd_ready && cmd_valid;
    assign hs         = in_ready && in_valid;
    assign take_abort = abort && (state_q == CLEAR || state_q == STREAM || state_q == DRAIN);
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cmd_valid ? CLEAR : IDLE;
            CLEAR:   state_d = len_q == '0 ? DRAIN : STREAM;
            STREAM:  state_d = hs && cnt_q + LEN_W'(1) == len_q ? DRAIN : STREAM;
            DRAIN:   state_d = wait_q == WW'(SORT_LAT - 1) ? FIN : DRAIN;
            default: state_d = IDLE;
        endcase
        if (take_abort) state_d = IDLE;
    end
    always_comb begin
        len_d            = acc ? cmd_len : len_q;
        base_d           = acc ? cmd_idx_base : base_q;
        misc_fun_id_d    = acc ? cmd_fun_id : misc_fun_id_q;
        misc_asce_d      = acc ? cmd_asce : misc_asce_q;
        cnt_d            = state_q == CLEAR ? '0 : hs ? cnt_q + LEN_W'(1) : cnt_q;
        wait_d           = state_q == DRAIN ? wait_q + WW'(1) : '0;
        misc_in_d        = hs ? in_data : misc_in_q;
        misc_index_d     = hs ? base_q + WIDTH'(cnt_q) : misc_index_q;
        misc_is_start_d  = hs;
        // an abort also wipes whatever the partial job left in the k-sort registers
        misc_clear_reg_d = state_q == CLEAR || take_abort;
        done_d           = state_q == FIN;
        aborted_d        = take_abort;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q            <= '0;
            base_q           <= '0;
            cnt_q            <= '0;
            wait_q           <= '0;
            misc_in_q        <= '0;
            misc_index_q     <= '0;
            misc_fun_id_q    <= '0;
            misc_asce_q      <= 1'b0;
            misc_is_start_q  <= 1'b0;
            misc_clear_reg_q <= 1'b0;
            done_q           <= 1'b0;
            aborted_q        <= 1'b0;
        end else begin
            len_q            <= len_d;
            base_q           <= base_d;
            cnt_q            <= cnt_d;
            wait_q           <= wait_d;
            misc_in_q        <= misc_in_d;
            misc_index_q     <= misc_index_d;
            misc_fun_id_q    <= misc_fun_id_d;
            misc_asce_q      <= misc_asce_d;
            misc_is_start_q  <= misc_is_start_d;
            misc_clear_reg_q <= misc_clear_reg_d;
            done_q           <= done_d;
            aborted_q        <= aborted_d;
        end
    end
    assign misc_in        = misc_in_q;
    assign misc_index     = misc_index_q;
    assign misc_fun_id    = misc_fun_id_q;
    assign misc_asce      = misc_asce_q;
    assign misc_is_start  = misc_is_start_q;
    assign misc_clear_reg = misc_clear_reg_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
`ifdef MISC_SEQ_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d, perf_jobs_q, perf_jobs_d;
    always_comb begin
        perf_stall_d = acc ? '0
                     : state_q == STREAM && !in_valid && perf_stall_q != '1 ? perf_stall_q + 32'd1
                     : perf_stall_q;
        perf_jobs_d  = done_d && perf_jobs_q != '1 ? perf_jobs_q + 32'd1 : perf_jobs_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_jobs_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_jobs_q  <= perf_jobs_d;
        end
    end
    assign perf_stall = perf_stall_q;
    assign perf_jobs  = perf_jobs_q;
`endif
endmodule

// File: tb/tb_misc_seq_ctrl.sv
// tb_misc_seq_ctrl: directed self-checking bench for misc_seq_ctrl
module tb_misc_seq_ctrl;
    localparam int SL = 2;
    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, cmd_asce, abort, in_valid, in_ready;
    logic [15:0] cmd_len;
    logic [31:0] cmd_idx_base, in_data, misc_in, misc_index;
    logic [2:0]  cmd_fun_id, misc_fun_id;
    logic        misc_asce, misc_is_start, misc_clear_reg, busy, done, aborted;
`ifdef MISC_SEQ_CTRL_PERF_EN
    logic [31:0] perf_stall, perf_jobs;
`endif
    int nassert = 0;
    int nfail = 0;
    logic [31:0] exp_d, exp_i;
    int n;

    misc_seq_ctrl #(.WIDTH(32), .LEN_W(16), .SORT_LAT(SL)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_asce(cmd_asce), .cmd_idx_base(cmd_idx_base), .cmd_fun_id(cmd_fun_id), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .misc_in(misc_in),
        .misc_index(misc_index), .misc_fun_id(misc_fun_id), .misc_asce(misc_asce),
        .misc_is_start(misc_is_start), .misc_clear_reg(misc_clear_reg), .busy(busy),
        .done(done), .aborted(aborted)
`ifdef MISC_SEQ_CTRL_PERF_EN
        , .perf_stall(perf_stall), .perf_jobs(perf_jobs)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [15:0] len, input logic asce, input logic [31:0] base, input logic [2:0] fun);
        cmd_valid = 1'b1; cmd_len = len; cmd_asce = asce; cmd_idx_base = base; cmd_fun_id = fun;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain_chk(input string tag);
        in_valid = 1'b0;
        for (int k = 1; k <= SL + 1; k++) begin
            tick();
            chk({tag, "_done"}, 32'(done), 32'(k == SL + 1));
            chk({tag, "_start"}, 32'(misc_is_start), 0);
        end
        chk({tag, "_busy_end"}, 32'(busy), 0);
        chk({tag, "_ready_end"}, 32'(cmd_ready), 1);
        tick();
        chk({tag, "_done_low"}, 32'(done), 0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_asce = 1'b0; cmd_idx_base = '0;
        cmd_fun_id = '0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_clear", 32'(misc_clear_reg), 0);
        chk("rst_start", 32'(misc_is_start), 0);
        chk("rst_index", misc_index, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_aborted", 32'(aborted), 0);

        // job 1: len 4, continuous samples 7,3,9,1
        cmd(16'd4, 1'b1, 32'd100, 3'd5);
        chk("j1_clear_state_busy", 32'(busy), 1);
        chk("j1_cmd_ready", 32'(cmd_ready), 0);
        chk("j1_asce", 32'(misc_asce), 1);
        chk("j1_fun", 32'(misc_fun_id), 5);
        chk("j1_clear_not_yet", 32'(misc_clear_reg), 0);
        tick();
        chk("j1_clear_pulse", 32'(misc_clear_reg), 1);
        chk("j1_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] dv [4];
            dv = '{32'd7, 32'd3, 32'd9, 32'd1};
            in_valid = 1'b1; in_data = dv[i];
            tick();
            chk("j1_start", 32'(misc_is_start), 1);
            chk("j1_data", misc_in, dv[i]);
            chk("j1_index", misc_index, 32'd100 + 32'(i));
            chk("j1_clear_low", 32'(misc_clear_reg), 0);
        end
        chk("j1_drain_in_ready", 32'(in_ready), 0);
        drain_chk("j1");

        // job 2: len 3 with gaps in in_valid
        cmd(16'd3, 1'b0, 32'd200, 3'd2);
        tick();
        chk("j2_clear_pulse", 32'(misc_clear_reg), 1);
        chk("j2_asce", 32'(misc_asce), 0);
        n = 0; exp_d = 32'd1; exp_i = 32'd103;
        for (int j = 0; j < 6; j++) begin
            logic [5:0] vp;
            vp = 6'b101001;
            in_valid = vp[j]; in_data = 32'(j + 10);
            tick();
            if (vp[j]) begin
                exp_d = 32'(j + 10); exp_i = 32'd200 + 32'(n); n++;
            end
            chk("j2_start", 32'(misc_is_start), 32'(vp[j]));
            chk("j2_data", misc_in, exp_d);
            chk("j2_index", misc_index, exp_i);
        end
        drain_chk("j2");

        // job 3: len 0 goes straight from clear to drain
        cmd(16'd0, 1'b1, 32'd5, 3'd1);
        tick();
        chk("j3_clear_pulse", 32'(misc_clear_reg), 1);
        chk("j3_in_ready", 32'(in_ready), 0);
        chk("j3_start", 32'(misc_is_start), 0);
        drain_chk("j3");

        // job 4: index wraps past 2^32
        cmd(16'd4, 1'b1, 32'hFFFF_FFFE, 3'd3);
        tick();
        exp_i = 32'hFFFF_FFFE;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            tick();
            chk("j4_index", misc_index, exp_i);
            exp_i = exp_i + 32'd1;
        end
        drain_chk("j4");

        // job 5: abort on the 2nd of 5 samples, then immediate new job
        cmd(16'd5, 1'b0, 32'd300, 3'd4);
        tick();
        in_valid = 1'b1; in_data = 32'hA0;
        tick();
        chk("j5_start0", 32'(misc_is_start), 1);
        in_data = 32'hA1; abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("j5_aborted", 32'(aborted), 1);
        chk("j5_abort_clear", 32'(misc_clear_reg), 1);
        chk("j5_busy", 32'(busy), 0);
        chk("j5_done", 32'(done), 0);
        chk("j5_cmd_ready", 32'(cmd_ready), 1);
        chk("j5_last_accepted", misc_in, 32'hA1);
        cmd(16'd1, 1'b1, 32'd50, 3'd6);
        chk("j6_busy", 32'(busy), 1);
        chk("j6_aborted_low", 32'(aborted), 0);
        chk("j6_fun", 32'(misc_fun_id), 6);
        tick();
        chk("j6_clear_pulse", 32'(misc_clear_reg), 1);
        in_valid = 1'b1; in_data = 32'h55;
        tick();
        chk("j6_index", misc_index, 32'd50);
        chk("j6_data", misc_in, 32'h55);
        drain_chk("j6");

        // job 7: reset during drain
        cmd(16'd1, 1'b1, 32'd77, 3'd7);
        tick();
        in_valid = 1'b1; in_data = 32'h99;
        tick();
        in_valid = 1'b0;
        chk("j7_in_drain", 32'(in_ready), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("j7_cmd_ready", 32'(cmd_ready), 1);
        chk("j7_busy", 32'(busy), 0);
        chk("j7_misc_in", misc_in, 0);
        chk("j7_index", misc_index, 0);
        chk("j7_fun", 32'(misc_fun_id), 0);
        chk("j7_asce", 32'(misc_asce), 0);
        chk("j7_clear", 32'(misc_clear_reg), 0);
        chk("j7_start", 32'(misc_is_start), 0);
        for (int k = 0; k < SL + 3; k++) begin
            tick();
            chk("j7_no_done", 32'(done), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
